serial_frame_loader: RTL and testbench
======================================

// Module: serial_frame_loader
// PURPOSE
//  Upstream stage of the n-bit register (thanhghi). Receives an asynchronous-style serial frame, one bit per
//  bit_en strobe: start bit (0), then n data bits LSB first, then stop bit (1).
//  Presents the assembled word on data_out and pulses data_valid for one clock.
//  data_out/data_valid connect directly to the register's input_data/input_enable.
// PARAMETERS
//  n        8   data word width in bits; legal range 2..32
// PORTS
//  clk         in   1   single system clock, rising-edge
//  rst         in   1   reset: synchronous, active-high
//  serial_in   in   1   serial line, idle high; sampled only when bit_en=1
//  bit_en      in   1   bit-rate strobe, 1 clk wide; serial_in is ignored when bit_en=0
//  data_out    out  n   last correctly framed word; holds value between frames
//  data_valid  out  1   1-clk pulse: data_out updated this cycle
//  frame_err   out  1   1-clk pulse: stop bit sampled as 0
//  busy        out  1   1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  - All outputs and state are registered.
//  - Reset (rst=1 at a clk edge), reset values:
//      state=IDLE, data_out=0, data_valid=0, frame_err=0, busy=0, shift register=0, bit counter=0.
//    Reset wins over every other event.
//    Reset mid-frame aborts the frame; no data_valid or frame_err is produced for it.
//  - FSM transitions, evaluated only on edges with bit_en=1; with bit_en=0 the state holds:
//      IDLE : serial_in=0 -> DATA, bit counter cleared; serial_in=1 -> stay IDLE.
//      DATA : shift register <= {serial_in, shift[n-1:1]} (LSB first); count++.
//             When count reaches n-1 (n-th data bit captured) -> STOP.
//      STOP : serial_in=1 -> data_out <= shift, data_valid=1 for the next cycle, -> IDLE.
//             serial_in=0 -> frame_err=1 for the next cycle, data_out unchanged, -> BREAK.
//      BREAK: stay until serial_in=1 is sampled, then -> IDLE.
//             A line held low is not treated as a new start bit.
//  - Latency: data_valid is high in the clk cycle right after the edge that sampled the stop bit.
//    Minimum frame length is n+2 bit_en strobes.
//  - Pulse behaviour: data_valid and frame_err are never high together.
//    Each clears on the next edge regardless of bit_en.
//  - Back-to-back frames: a start bit on the strobe right after the stop bit is accepted (IDLE->DATA).
//  - Bit counter width: $clog2(n). It wraps to 0 on entering DATA, never beyond n-1.
//  - busy=1 in DATA, STOP and BREAK. busy=0 in the cycle data_valid is high.
//  - bit_en held at 1 continuously is legal: one bit per clk.
// STRUCTURE
//  - Shared package/include: state localparams IDLE=2'd0, DATA=2'd1, STOP=2'd2, BREAK=2'd3,
//    plus a default width constant of 8.
//  - Sub-module bit_counter: sync-clear, enable-increment, terminal-count flag at n-1, parameter n.
//  - Top level: FSM, shift register, output registers.
// TESTING (n=8, bit_en every 4th clk unless stated)
//  1. Reset: rst=1 for 2 clk -> data_out=8'h00, data_valid=0, frame_err=0, busy=0.
//  2. Good frame 8'hA5: line bits 0,1,0,1,0,0,1,0,1,1 on strobes
//     -> one data_valid pulse, data_out=8'hA5, busy back to 0.
//  3. Bad stop: frame 8'h3C with stop bit=0 -> frame_err pulse, data_out keeps 8'hA5, busy=1 until line=1.
//  4. Back-to-back: 8'h01 then 8'hFF with no idle strobe between
//     -> two data_valid pulses, data_out 8'h01 then 8'hFF.
//  5. Glitch immunity: serial_in toggles while bit_en=0, line=1 on all strobes -> stays IDLE, no pulses.
//  6. Reset mid-frame: rst after 4 data bits, then a clean frame 8'h5A
//     -> no pulse for the aborted frame, data_out=8'h5A.
//  Bench also checks data_valid feeds thanhghi: Out=data_out one clk after the pulse.

Source files
------------

// File: rtl/serial_frame_loader_pkg.sv
// Shared types and constants for the serial frame loader: FSM state encoding,
// default word width and the bit-counter width helper.
package serial_frame_loader_pkg;

  localparam int DEF_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  // Counter must index 0..w-1; a 1-bit counter is the floor for w=2.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_frame_loader_bit_counter.sv
// Data-bit counter: synchronous clear, enable-increment, wraps to 0 after n-1,
// and flags the terminal count so the FSM knows the last data bit is arriving.
module bit_counter
  import serial_frame_loader_pkg::*;
#(
  parameter int n = DEF_N
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = cnt_width(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_frame_loader.sv
// Serial frame receiver: start(0), n data bits LSB first, stop(1), one bit per
// bit_en strobe. Emits the word with a 1-clk data_valid, or a 1-clk frame_err.
module serial_frame_loader
  import serial_frame_loader_pkg::*;
#(
  parameter int n = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         serial_in,
  input  logic         bit_en,
  output logic [n-1:0] data_out,
  output logic         data_valid,
  output logic         frame_err,
  output logic         busy
);

  state_t         state_q;
  logic [n-1:0]   shift_q;
  logic [n-1:0]   shift_d;
  logic [n-1:0]   data_q;
  logic           dv_q;
  logic           err_q;
  logic           busy_q;
  logic           cnt_clr;
  logic           cnt_en;
  logic           cnt_tc;

  assign shift_d = {serial_in, shift_q[n-1:1]};
  assign cnt_clr = bit_en && (state_q == IDLE) && !serial_in;
  assign cnt_en  = bit_en && (state_q == DATA);

  bit_counter #(.n(n)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle, independent of the strobe cadence.
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!serial_in) begin
              state_q <= DATA;
              busy_q  <= 1'b1;
            end
          end
          DATA: begin
            shift_q <= shift_d;
            if (cnt_tc) state_q <= STOP;
          end
          STOP: begin
            if (serial_in) begin
              data_q  <= shift_q;
              dv_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= BREAK;
            end
          end
          BREAK: begin
            // A low line here is a continuing break, never a fresh start bit.
            if (serial_in) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_loader.sv
// Bench for serial_frame_loader: directed frames plus randomized traffic, all
// outputs compared every cycle against a bit-position model of the framing rules.
module tb_serial_frame_loader;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         serial_in;
  logic         bit_en;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         frame_err;
  logic         busy;

  int errors = 0;
  int checks = 0;

  serial_frame_loader #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: m_pos = -1 idle, 0..N-1 next data bit index, N awaiting stop.
  int           m_pos = -1;
  bit           m_brk = 1'b0;
  logic [N-1:0] m_word = '0;
  logic [N-1:0] m_data = '0;
  bit           m_dv = 1'b0;
  bit           m_err = 1'b0;

  always @(posedge clk) begin
    m_dv  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_pos = -1; m_brk = 1'b0; m_data = '0; m_word = '0;
    end else if (bit_en) begin
      if (m_brk) begin
        if (serial_in) m_brk = 1'b0;
      end else if (m_pos < 0) begin
        if (!serial_in) m_pos = 0;
      end else if (m_pos < N) begin
        m_word[m_pos] = serial_in;
        m_pos++;
      end else begin
        if (serial_in) begin m_data = m_word; m_dv = 1'b1; end
        else begin m_err = 1'b1; m_brk = 1'b1; end
        m_pos = -1;
      end
    end
  end

  // Downstream register fed by data_out/data_valid.
  logic [N-1:0] tg_q = '0;
  always @(posedge clk) if (data_valid) tg_q <= data_out;

  bit           chk_on = 1'b0;
  bit           prev_dv = 1'b0;
  int           dv_n = 0;
  int           err_n = 0;
  logic [N-1:0] dv_log[$];

  always @(negedge clk) begin
    if (chk_on) begin
      check("data_out", 32'(data_out), 32'(m_data));
      check("data_valid", 32'(data_valid), 32'(m_dv));
      check("frame_err", 32'(frame_err), 32'(m_err));
      check("busy", 32'(busy), 32'(m_brk || (m_pos >= 0)));
      check("dv_err_excl", 32'(data_valid & frame_err), 32'd0);
      if (prev_dv) check("thanhghi_out", 32'(tg_q), 32'(m_data));
      if (data_valid) begin dv_n++; dv_log.push_back(data_out); end
      if (frame_err) err_n++;
      prev_dv = m_dv;
    end
  end

  task automatic cyc(input logic sin, input logic en);
    serial_in = sin;
    bit_en    = en;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap, input bit glitch);
    cyc(b, 1'b1);
    for (int i = 1; i < gap; i++) cyc(glitch ? logic'($urandom_range(0, 1)) : b, 1'b0);
  endtask

  task automatic send_frame(input logic [N-1:0] w, input logic stop, input int gap, input bit glitch);
    strobe(1'b0, gap, glitch);
    for (int i = 0; i < N; i++) strobe(w[i], gap, glitch);
    strobe(stop, gap, glitch);
  endtask

  initial begin
    int d0;
    int e0;
    rst = 1'b1; serial_in = 1'b1; bit_en = 1'b0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Good frame A5
    send_frame(8'hA5, 1'b1, 4, 1'b0);
    check("a5_dv_count", 32'(dv_n), 32'd1);
    check("a5_data_out", 32'(data_out), 32'hA5);
    check("a5_model", 32'(m_data), 32'hA5);
    check("a5_busy", 32'(busy), 32'd0);
    check("a5_thanhghi", 32'(tg_q), 32'hA5);

    // Bad stop: 3C with stop=0, then line held low a while (break)
    send_frame(8'h3C, 1'b0, 4, 1'b0);
    strobe(1'b0, 4, 1'b0);
    strobe(1'b0, 4, 1'b0);
    check("brk_err_count", 32'(err_n), 32'd1);
    check("brk_dv_count", 32'(dv_n), 32'd1);
    check("brk_data_kept", 32'(data_out), 32'hA5);
    check("brk_busy", 32'(busy), 32'd1);
    strobe(1'b1, 4, 1'b0);
    check("brk_release", 32'(busy), 32'd0);

    // Back-to-back 01 then FF
    send_frame(8'h01, 1'b1, 4, 1'b0);
    send_frame(8'hFF, 1'b1, 4, 1'b0);
    check("b2b_dv_count", 32'(dv_n), 32'd3);
    check("b2b_first", 32'(dv_log[1]), 32'h01);
    check("b2b_second", 32'(dv_log[2]), 32'hFF);

    // Glitch immunity: line high on every strobe, toggling between them
    d0 = dv_n; e0 = err_n;
    for (int i = 0; i < 10; i++) strobe(1'b1, 4, 1'b1);
    check("glitch_no_dv", 32'(dv_n), 32'(d0));
    check("glitch_no_err", 32'(err_n), 32'(e0));
    check("glitch_idle", 32'(busy), 32'd0);

    // Reset mid-frame after 4 data bits, then clean 5A
    strobe(1'b0, 4, 1'b0);
    for (int i = 0; i < 4; i++) strobe(logic'(i[0]), 4, 1'b0);
    rst = 1'b1; cyc(1'b1, 1'b0); rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    send_frame(8'h5A, 1'b1, 4, 1'b0);
    check("abort_dv_count", 32'(dv_n), 32'(d0 + 1));
    check("abort_err_count", 32'(err_n), 32'(e0));
    check("abort_data_out", 32'(data_out), 32'h5A);

    // Continuous bit_en: one bit per clk, back-to-back
    send_frame(8'h81, 1'b1, 1, 1'b0);
    send_frame(8'h7E, 1'b1, 1, 1'b0);
    cyc(1'b1, 1'b0);
    check("cont_data_out", 32'(data_out), 32'h7E);

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      int gap;
      logic [N-1:0] w;
      gap = $urandom_range(1, 5);
      w = N'($urandom);
      case ($urandom_range(0, 9))
        0: begin
          strobe(1'b0, gap, 1'b1);
          for (int i = 0; i < int'($urandom_range(0, N)); i++) strobe(logic'($urandom_range(0, 1)), gap, 1'b1);
          rst = 1'b1; cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1))); rst = 1'b0;
        end
        1: for (int i = 0; i < int'($urandom_range(1, 3)); i++) strobe(1'b1, gap, 1'b1);
        2: begin
          send_frame(w, 1'b0, gap, 1'b1);
          for (int i = 0; i < int'($urandom_range(0, 3)); i++) strobe(1'b0, gap, 1'b1);
          strobe(1'b1, gap, 1'b1);
        end
        default: send_frame(w, 1'b1, gap, $urandom_range(0, 1) == 1);
      endcase
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
